// File: rtl/uart_tx_fifo_loader_pkg.sv
// Shared types and defaults for the UART TX FIFO loader.
// Sequencer state encodings and the default payload width.
package uart_tx_fifo_loader_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LAUNCH    = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/uart_sync_fifo_mem.sv
// Synchronous FIFO storage, pointers, count and status flags.
// Optional level/almost_full outputs under UART_TX_FIFO_LEVEL_EN.
module uart_sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
`endif
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_next = count;
    unique case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // Pointers, count and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count;

  // Registered near-full indication
  always_ff @(posedge clk) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (count_next >= AF_CNT);
  end
`endif

endmodule

// File: rtl/uart_tx_fifo_loader.sv
// UART TX byte buffer and launch sequencer in front of the TX FSM.
// Optional macro UART_TX_FIFO_LEVEL_EN adds fifo_level/almost_full.
module uart_tx_fifo_loader
  import uart_tx_fifo_loader_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  tx_busy,
  output logic                  data_valid,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  almost_full,
`endif
  output logic [DATA_WIDTH-1:0] p_data
);

  seq_state_t            state;
  seq_state_t            next_state;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_data;

  uart_sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk1),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (pop),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
`ifdef UART_TX_FIFO_LEVEL_EN
    .level       (fifo_level),
    .almost_full (almost_full),
`endif
    .overflow    (overflow)
  );

  // Launch sequencing: pop only with TX idle, then track one busy window
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH:    next_state = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) next_state = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State, launch pulse and frame byte registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      data_valid <= 1'b0;
      p_data     <= '0;
    end else begin
      state      <= next_state;
      data_valid <= pop;
      if (pop) p_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_loader.sv
// Directed bench for uart_tx_fifo_loader (vector table + sequences).
// Level checks compile in when UART_TX_FIFO_LEVEL_EN is defined.
module tb_uart_tx_fifo_loader;

  logic       clk1;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_busy;
  logic       data_valid;
  logic [7:0] p_data;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [3:0] fifo_level;
  logic       almost_full;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_fifo_loader dut (
    .clk1        (clk1),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .tx_busy     (tx_busy),
    .data_valid  (data_valid),
`ifdef UART_TX_FIFO_LEVEL_EN
    .fifo_level  (fifo_level),
    .almost_full (almost_full),
`endif
    .p_data      (p_data)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] din;
    logic       busy;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_dv;
    logic [7:0] e_pd;
  } vec_t;

  vec_t vt[16];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait for a launch, check the byte, then model an 11-cycle busy window
  task automatic frame(input logic [7:0] exp, input string nm);
    int n;
    n = 0;
    tx_busy = 1'b0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_launch_timeout"}, 32'(n < 20), 32'd1);
    chk({nm, "_pdata"}, 32'(p_data), 32'(exp));
    tx_busy = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk({nm, "_stable"}, 32'(p_data), 32'(exp));
      chk({nm, "_no_dv"}, 32'(data_valid), 32'd0);
    end
    tx_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;

    // rst wr din busy | full empty ovf dv pdata
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[9]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
    vt[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
    vt[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
    vt[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};

    for (int i = 0; i < 16; i++) begin
      rst     = vt[i].rst;
      wr_en   = vt[i].wr;
      wr_data = vt[i].din;
      tx_busy = vt[i].busy;
      tick();
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].e_full));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d_dv", i), 32'(data_valid), 32'(vt[i].e_dv));
      chk($sformatf("v%0d_pdata", i), 32'(p_data), 32'(vt[i].e_pd));
    end
    wr_en = 1'b0;

    // Burst 0x01..0x08 with TX stalled, then overflow attempt
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i + 1);
      tick();
      chk($sformatf("burst%0d_full", i), 32'(full), 32'(i == 7));
    end
    chk("burst_empty", 32'(empty), 32'd0);
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);

    for (int i = 0; i < 8; i++)
      frame(8'(i + 1), $sformatf("frame%0d", i));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("no_ff_launch", 32'(data_valid), 32'd0);
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_pdata", 32'(p_data), 32'h08);

    // Reset during WAIT_DONE with three entries queued
    wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    tick();
    chk("r_dv", 32'(data_valid), 32'd1);
    chk("r_pdata", 32'(p_data), 32'h11);
    tx_busy = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h22; tick();
    wr_data = 8'h33; tick();
    wr_data = 8'h44; tick();
    wr_en = 1'b0;
    tick();
    chk("r_queued", 32'(empty), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_empty", 32'(empty), 32'd1);
    chk("r_full", 32'(full), 32'd0);
    chk("r_dv0", 32'(data_valid), 32'd0);
    chk("r_pdata0", 32'(p_data), 32'h00);
    chk("r_ovf_clr", 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("r_level", 32'(fifo_level), 32'd0);
    chk("r_af", 32'(almost_full), 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_busy_no_dv", 32'(data_valid), 32'd0);
    end
    tx_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_idle_no_dv", 32'(data_valid), 32'd0);
      chk("r_idle_empty", 32'(empty), 32'd1);
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    // Level tracking: one launch, then 7 writes with TX stalled
    wr_en = 1'b1; wr_data = 8'h50;
    tick();
    wr_en = 1'b0;
    chk("lv_first", 32'(fifo_level), 32'd1);
    tick();
    chk("lv_popped", 32'(fifo_level), 32'd0);
    chk("lv_dv", 32'(data_valid), 32'd1);
    tx_busy = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h50 + i);
      tick();
      chk($sformatf("lv%0d", i), 32'(fifo_level), 32'(i));
      chk($sformatf("af%0d", i), 32'(almost_full), 32'(i >= 7));
    end
    wr_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
